// File: rtl/alu_pkg.sv
// Shared definitions for the sequential adder/subtractor: FSM encoding and
// sizing helpers used by the top level and the testbench.
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } alu_state_e;

   // Number of digit steps needed to cover the full operand width.
   function automatic int digitCount(input int width, input int digit);
      return width / digit;
   endfunction

   // Counter must be at least one bit wide even for single-digit operation.
   function automatic int counterWidth(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mbledhesi_digit.sv
// One DIGIT-wide ripple slice built from 1-bit full-adder cells; also exposes
// the carry into its top bit so the caller can derive signed overflow.
module mbledhesi_fa (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (a_i & c_i) | (b_i & c_i);

endmodule

module mbledhesi_digit #(
   parameter int DIGIT = 4
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] carryChain;

   assign carryChain[0] = cin;

   for (genvar i = 0; i < DIGIT; i++) begin : g_bit
      mbledhesi_fa u_fa (
         .a_i (x[i]),
         .b_i (y[i]),
         .c_i (carryChain[i]),
         .s_o (s[i]),
         .c_o (carryChain[i+1])
      );
   end

   assign cout = carryChain[DIGIT];
   assign cmsb = carryChain[DIGIT-1];

endmodule

// File: rtl/mbledhesi_sekuencial.sv
// Multi-cycle adder/subtractor: adds DIGIT bits per clock, LSB digit first,
// with a start/busy/done handshake and carry/overflow/zero flags.
module mbledhesi_sekuencial
   import alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             overflow,
   output logic             zero
);

   localparam int N  = digitCount(WIDTH, DIGIT);
   localparam int CW = counterWidth(N);
   localparam logic [CW-1:0] LAST_DIGIT = CW'(N - 1);

   alu_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] aOp_q;
   logic [WIDTH-1:0] bOp_q;
   logic             carry_q;
   logic [WIDTH-1:0] work_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             ovf_q;
   logic             zero_q;
   logic             busy_q;
   logic             done_q;

   logic [DIGIT-1:0] aDigit;
   logic [DIGIT-1:0] bDigit;
   logic [DIGIT-1:0] digitSum;
   logic             digitCout;
   logic             digitCmsb;
   logic [WIDTH-1:0] work_d;
   int               digitBase;

   // Select the digit currently being processed and merge its sum into the
   // working copy; sum only sees the working register once all digits are in.
   always_comb begin
      digitBase = int'(cnt_q) * DIGIT;
      aDigit    = aOp_q[digitBase +: DIGIT];
      bDigit    = bOp_q[digitBase +: DIGIT];
      work_d    = work_q;
      work_d[digitBase +: DIGIT] = digitSum;
   end

   mbledhesi_digit #(
      .DIGIT (DIGIT)
   ) u_digit (
      .x    (aDigit),
      .y    (bDigit),
      .cin  (carry_q),
      .s    (digitSum),
      .cout (digitCout),
      .cmsb (digitCmsb)
   );

   // Subtraction is A + ~B + 1: the inverted operand is stored and the
   // carry register is preloaded with the sub flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         aOp_q   <= '0;
         bOp_q   <= '0;
         carry_q <= 1'b0;
         work_q  <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE, FIN: begin
               done_q <= 1'b0;
               if (start) begin
                  aOp_q   <= a;
                  bOp_q   <= sub ? ~b : b;
                  carry_q <= sub;
                  cnt_q   <= '0;
                  work_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= RUN;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            RUN: begin
               work_q  <= work_d;
               carry_q <= digitCout;
               cnt_q   <= cnt_q + 1'b1;
               if (cnt_q == LAST_DIGIT) begin
                  sum_q   <= work_d;
                  cout_q  <= digitCout;
                  ovf_q   <= digitCmsb ^ digitCout;
                  zero_q  <= (work_d == '0);
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= FIN;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign cout     = cout_q;
   assign overflow = ovf_q;
   assign zero     = zero_q;

endmodule

// File: doc/mbledhesi_sekuencial.md
Name: mbledhesi_sekuencial

Overview:
- Parametrised, multi-cycle adder/subtractor for the CPU datapath.
- Processes a WIDTH-bit operation DIGIT bits per clock, least-significant digit first, with the carry held in a register between digits.
- Uses a start/busy/done handshake.
- Adds subtraction and ALU flags (carry, signed overflow, zero).
- Lets the ALU trade latency for area in place of a full-width combinational ripple adder.

Parameters:
- WIDTH, 16, operand/result width in bits. WIDTH >= 2.
- DIGIT, 4, bits processed per cycle. WIDTH must be a multiple of DIGIT; DIGIT = WIDTH gives single-digit operation.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request a new operation; sampled only when busy=0.
- sub  input  1  0 = A+B, 1 = A-B. Captured with start.
- a  input  WIDTH  operand A. Captured with start.
- b  input  WIDTH  operand B. Captured with start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse when the result becomes valid.
- sum  output  WIDTH  result. Held until the next accepted start.
- cout  output  1  carry out of the MSB. For sub this is "no borrow" (1 when A >= B unsigned).
- overflow  output  1  two's-complement signed overflow.
- zero  output  1  high when sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; busy, done, cout, overflow = 0; sum = 0; zero = 1; digit counter and internal registers cleared. Reset mid-operation aborts the operation with no done pulse.
- N = WIDTH/DIGIT. FSM states:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: busy=0, done=1.
- Acceptance: start=1 at a rising edge in IDLE or FIN captures a, b and sub.
  - The captured operand is b when sub=0 and ~b when sub=1.
  - The carry register is loaded with sub.
  - The digit counter goes to 0 and the FSM goes to RUN.
- Ignored starts: start while in RUN is ignored; the operation in flight continues and its operands are unchanged.
- RUN, each edge:
  - digit k = counter is added: {c, s} = A[k] + Bop[k] + carry.
  - s is written into digit k of the result register and c into the carry register.
  - The counter increments.
  - On the edge that processes digit N-1, the FSM goes to FIN.
- Latency: start sampled at edge t gives busy=1 during cycles t+1..t+N. done=1 and valid results appear in the cycle after edge t+N.
  - Start-to-done is N+1 edges (N=4 → 5).
  - Back-to-back starts give one result every N+1 cycles.
- FIN lasts exactly one cycle, then returns to IDLE unless start is accepted. Outputs remain stable in IDLE.
- Result outputs:
  - sum, cout, overflow and zero are updated only at the final digit edge.
  - Intermediate digits are not visible on sum. Use a shadow/working register, copied at completion.
  - overflow = carry into MSB XOR carry out of MSB, taken from the final digit.
  - zero is computed from the completed result.
- Width arithmetic: modulo 2^WIDTH; the carry beyond the MSB appears only on cout.

Decomposition:
- Shared package (alu_pkg):
  - FSM state encoding IDLE/RUN/FIN.
  - Constant function for the digit count N.
  - Counter width, $clog2(N) with a minimum of 1.
- One natural sub-module, mbledhesi_digit:
  - Combinational DIGIT-bit ripple adder built from the team's 1-bit full-adder cell.
  - Ports: x, y, cin, s, cout, plus cmsb (carry into the top bit) for overflow.
- The top level holds the FSM, counter, operand/carry registers and flags.

Test Plan:
- WIDTH=16, DIGIT=4, sub=0, a=10, b=9 → after 5 edges: done pulse, sum=19, cout=0, overflow=0, zero=0; busy high for exactly 4 cycles.
- a=16'hFFFF, b=1, sub=0 → sum=0, cout=1, zero=1, overflow=0.
- a=16'h7FFF, b=1, sub=0 → sum=16'h8000, overflow=1, cout=0.
- sub=1: a=20, b=9 → sum=11, cout=1. Then a=9, b=20 → sum=16'hFFF5, cout=0, overflow=0. Then a=16'h8000, b=1 → sum=16'h7FFF, overflow=1.
- Handshake and reset:
  - start pulsed again during RUN with different operands → ignored; first result unchanged.
  - start asserted in the FIN cycle → accepted; next done arrives 5 edges later.
  - rst_n low mid-RUN → immediate busy=0, sum=0, zero=1, no done pulse.
- Parameter sweep: DIGIT=16 (N=1, done 2 edges after start) and DIGIT=1 (N=16, done 17 edges after start). Random operands compared against a+b or a-b, including cout and overflow.
